signed_to_unsigned_stream: RTL and testbench

//  Inverse of the DDS unsigned->signed stage: maps 14-bit signed DDS/ADC-path samples back to

---
 rtl/signed_to_unsigned_stream_if.sv | 41 ++++
 rtl/signed_to_unsigned_stream.sv | 122 ++++++++++++
 tb/tb_signed_to_unsigned_stream.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/signed_to_unsigned_stream_if.sv
// Stream interface for the signed->offset-binary converter: enable-strobed
// input side, valid/ready output side, plus the overrun status/clear pair.
interface signed_to_unsigned_stream_if #(
  parameter int unsigned DATA_W = 14
);
  logic [DATA_W-1:0] dds_data_signed;
  logic              dds_signed_en;
  logic              dds_ready;
  logic [DATA_W-1:0] dds_data_unsigned;
  logic              dds_unsigned_en;
  logic              dds_unsigned_ready;
  logic              dds_unsigned_last;
  logic              overrun;
  logic              overrun_clr;

  // Environment side: drives samples, downstream ready and the clear.
  modport master (
    output dds_data_signed,
    output dds_signed_en,
    input  dds_ready,
    input  dds_data_unsigned,
    input  dds_unsigned_en,
    output dds_unsigned_ready,
    input  dds_unsigned_last,
    input  overrun,
    output overrun_clr
  );

  // Converter side.
  modport slave (
    input  dds_data_signed,
    input  dds_signed_en,
    output dds_ready,
    output dds_data_unsigned,
    output dds_unsigned_en,
    input  dds_unsigned_ready,
    output dds_unsigned_last,
    output overrun,
    input  overrun_clr
  );
endinterface

// File: rtl/signed_to_unsigned_stream.sv
// Signed DDS/ADC sample -> offset-binary unsigned (u = MID - s, wrapping),
// presented as a valid/ready stream behind a 2-entry skid buffer (OUT + SKID),
// with frame-last tagging every FRAME_LEN accepted samples and a sticky
// overrun flag for strobes that arrive while the buffer is full.
module signed_to_unsigned_stream #(
  parameter int unsigned DATA_W    = 14,
  parameter int unsigned FRAME_LEN = 1024,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  signed_to_unsigned_stream_if.slave    strm
);

  localparam logic [DATA_W-1:0] MID      = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              skid_last_q, skid_last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovr_q, ovr_d;

  logic              accept;
  logic              drain;
  logic              in_last;
  logic [DATA_W-1:0] in_conv;

  // Ready and valid come straight from the occupancy register, so there is
  // no combinational path from dds_unsigned_ready back to dds_ready.
  assign strm.dds_ready         = (state_q != ST_FULL);
  assign strm.dds_unsigned_en   = (state_q != ST_EMPTY);
  assign strm.dds_data_unsigned = out_data_q;
  assign strm.dds_unsigned_last = out_last_q;
  assign strm.overrun           = ovr_q;

  assign accept  = strm.dds_signed_en && (state_q != ST_FULL);
  assign drain   = (state_q != ST_EMPTY) && strm.dds_unsigned_ready;
  assign in_conv = MID - strm.dds_data_signed;
  assign in_last = (cnt_q == LAST_CNT);

  // Occupancy FSM, data movement between input/OUT/SKID, frame count, overrun.
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    cnt_d       = cnt_q;
    ovr_d       = ovr_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          out_data_d = in_conv;
          out_last_d = in_last;
          state_d    = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && !drain) begin
          skid_data_d = in_conv;
          skid_last_d = in_last;
          state_d     = ST_FULL;
        end else if (accept && drain) begin
          out_data_d = in_conv;
          out_last_d = in_last;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (drain) begin
          out_data_d = skid_data_q;
          out_last_d = skid_last_q;
          state_d    = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    if (accept) begin
      cnt_d = in_last ? '0 : cnt_q + CNT_W'(1);
    end

    if (strm.dds_signed_en && (state_q == ST_FULL)) begin
      ovr_d = 1'b1;
    end else if (strm.overrun_clr) begin
      ovr_d = 1'b0;
    end
  end

  // State register with synchronous reset; reset discards buffered samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      skid_data_q <= '0;
      skid_last_q <= 1'b0;
      cnt_q       <= '0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      skid_data_q <= skid_data_d;
      skid_last_q <= skid_last_d;
      cnt_q       <= cnt_d;
      ovr_q       <= ovr_d;
    end
  end

endmodule

// File: tb/tb_signed_to_unsigned_stream.sv
// Bench for signed_to_unsigned_stream with FRAME_LEN=4: directed steps plus
// a random soak, checked against an occupancy/queue scoreboard model.
module tb_signed_to_unsigned_stream;

  localparam int unsigned DW = 14;
  localparam int unsigned FL = 4;
  localparam logic [DW-1:0] MID = 14'h1FFF;

  logic clk;
  logic rst;

  signed_to_unsigned_stream_if #(.DATA_W(DW)) bus ();

  signed_to_unsigned_stream #(
    .DATA_W    (DW),
    .FRAME_LEN (FL),
    .CNT_W     (16)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .strm (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Scoreboard: {last, data} for every accepted sample still buffered.
  logic [DW:0] sb[$];
  int          m_occ = 0;
  int          m_cnt = 0;
  logic        m_ovr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, update the model at posedge, check at negedge.
  task automatic step(input logic r, input logic e, input logic [DW-1:0] d,
                      input logic rdy, input logic clr);
    logic acc, drn;
    rst                    = r;
    bus.dds_signed_en      = e;
    bus.dds_data_signed    = d;
    bus.dds_unsigned_ready = rdy;
    bus.overrun_clr        = clr;
    acc = !r && e && (m_occ < 2);
    drn = !r && rdy && (m_occ > 0);
    @(posedge clk);
    if (r) begin
      m_occ = 0;
      m_cnt = 0;
      m_ovr = 1'b0;
      sb.delete();
    end else begin
      if (drn) void'(sb.pop_front());
      if (acc) begin
        sb.push_back({(m_cnt == int'(FL) - 1), MID - d});
        m_cnt = (m_cnt == int'(FL) - 1) ? 0 : m_cnt + 1;
      end
      m_ovr = (e && m_occ == 2) ? 1'b1 : (clr ? 1'b0 : m_ovr);
      m_occ = m_occ + int'(acc) - int'(drn);
    end
    @(negedge clk);
    chk("ready",   32'(bus.dds_ready),       32'(m_occ < 2));
    chk("valid",   32'(bus.dds_unsigned_en), 32'(m_occ > 0));
    chk("overrun", 32'(bus.overrun),         32'(m_ovr));
    if (m_occ > 0) begin
      chk("data", 32'(bus.dds_data_unsigned), 32'(sb[0][DW-1:0]));
      chk("last", 32'(bus.dds_unsigned_last), 32'(sb[0][DW]));
    end
    if (r) begin
      chk("rst_data", 32'(bus.dds_data_unsigned), 32'h0);
      chk("rst_last", 32'(bus.dds_unsigned_last), 32'h0);
    end
  endtask

  initial begin
    logic [DW-1:0] map_in[5];
    logic [DW-1:0] map_out[5];
    map_in  = '{14'h0000, 14'h1FFF, 14'h2000, 14'h3FFF, 14'h0001};
    map_out = '{14'h1FFF, 14'h0000, 14'h3FFF, 14'h2000, 14'h1FFE};

    rst                    = 1'b1;
    bus.dds_signed_en      = 1'b0;
    bus.dds_data_signed    = '0;
    bus.dds_unsigned_ready = 1'b0;
    bus.overrun_clr        = 1'b0;

    // 1: reset held 3 cycles with the strobe active
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 14'h1234, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("post_rst_ready", 32'(bus.dds_ready), 32'h1);

    // 2: mapping examples, one cycle latency, ready held high
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, map_in[i], 1'b1, 1'b0);
      chk("map_value", 32'(bus.dds_data_unsigned), 32'(map_out[i]));
    end
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);

    // 3: backpressure mid-stream, drops while FULL, in-order recovery
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, DW'(i), !(i >= 3 && i < 6), 1'b0);
      if (i == 4) chk("full_ready", 32'(bus.dds_ready), 32'h0);
    end
    chk("ovr_set", 32'(bus.overrun), 32'h1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);

    // 4: framing from a clean counter, last on beats 3, 7, 11
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, DW'(100 + i), 1'b1, 1'b0);
      chk("frame_valid", 32'(bus.dds_unsigned_en), 32'h1);
      chk("frame_last",  32'(bus.dds_unsigned_last), 32'((i % 4) == 3));
    end
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);

    // 5: set/clear race; fill the buffer then drop with clear asserted
    step(1'b0, 1'b1, 14'h0AAA, 1'b0, 1'b0);
    step(1'b0, 1'b1, 14'h0BBB, 1'b0, 1'b0);
    step(1'b0, 1'b1, 14'h0CCC, 1'b0, 1'b1);
    chk("clr_race", 32'(bus.overrun), 32'h1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("clr_alone", 32'(bus.overrun), 32'h0);

    // 6: reset while FULL, then a fresh frame of 4
    chk("pre_rst_full", 32'(bus.dds_ready), 32'h0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk("midrst_valid", 32'(bus.dds_unsigned_en), 32'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, DW'(i), 1'b1, 1'b0);
    chk("midrst_last", 32'(bus.dds_unsigned_last), 32'h1);

    // random soak against the scoreboard
    for (int i = 0; i < 10000; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), DW'($urandom),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
